// File: rtl/connect_win_scanner.sv
// Multi-cycle Connect-4 win scanner: snapshots one player board on start and scans one anchor row per clock.
// Optional draw detection is compiled in with CONNECT_DRAW_DETECT_EN.
module connect_win_scanner #(
   parameter int ROWS    = 6,
   parameter int COLS    = 7,
   parameter int WIN_LEN = 4,
   parameter int PLAYERS = 2,
   parameter int PW      = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [PLAYERS*ROWS*COLS-1:0]  boards,
   input  logic [PW-1:0]                 player,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          win,
   output logic [ROWS*COLS-1:0]          win_mask,
   output logic                          draw
);

   localparam int CELLS = ROWS * COLS;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CELLS-1:0] ONE = CELLS'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [RW-1:0]      r_row;
   logic [CELLS-1:0]   r_board;
   logic               r_win;
   logic [CELLS-1:0]   r_mask;
   logic [CELLS-1:0]   w_sel;
   logic [CELLS-1:0]   w_row_mask;
   logic               w_row_win;
   logic               w_accept;
   logic               w_last;

   // Mask of the run anchored at (r,c) stepping (dr,dc); zero if off-board or not fully occupied.
   function automatic logic [CELLS-1:0] run_mask(input logic [CELLS-1:0] b, input int r, input int c,
                                                 input int dr, input int dc);
      logic [CELLS-1:0] m;
      logic [CELLS-1:0] t;
      logic             hit;
      int               er;
      int               ec;
      int               idx;
      m   = '0;
      hit = 1'b1;
      er  = r + dr * (WIN_LEN - 1);
      ec  = c + dc * (WIN_LEN - 1);
      if (er < 0 || er >= ROWS || ec >= COLS) begin
         hit = 1'b0;
      end else begin
         for (int k = 0; k < WIN_LEN; k++) begin
            idx = (r + dr * k) * COLS + c + dc * k;
            t   = b >> idx;
            hit = hit & t[0];
            m   = m | (ONE << idx);
         end
      end
      return hit ? m : '0;
   endfunction

   assign w_accept = start && (r_state != S_SCAN);
   assign w_last   = (r_row == RW'(ROWS - 1));

   // A player index with no board selects an empty board, so the scan finds nothing.
   always_comb begin
      w_sel = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         if (int'(player) == p) begin
            w_sel = boards[p*CELLS +: CELLS];
         end
      end
   end

   always_comb begin
      w_row_mask = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (r_row == RW'(r)) begin
               w_row_mask = w_row_mask
                          | run_mask(r_board, r, c, 0, 1)
                          | run_mask(r_board, r, c, 1, 0)
                          | run_mask(r_board, r, c, 1, 1)
                          | run_mask(r_board, r, c, -1, 1);
            end
         end
      end
      w_row_win = |w_row_mask;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = S_SCAN;
         S_SCAN:  if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = start ? S_SCAN : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_row   <= '0;
         r_board <= '0;
         r_win   <= 1'b0;
         r_mask  <= '0;
      end else if (w_accept) begin
         r_board <= w_sel;
         r_row   <= '0;
         r_win   <= 1'b0;
         r_mask  <= '0;
      end else if (r_state == S_SCAN) begin
         r_mask <= r_mask | w_row_mask;
         r_win  <= r_win | w_row_win;
         r_row  <= w_last ? '0 : r_row + 1'b1;
      end
   end

`ifdef CONNECT_DRAW_DETECT_EN
   logic [CELLS-1:0] r_occ;
   logic [CELLS-1:0] w_occ;
   logic             r_draw;

   always_comb begin
      w_occ = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         w_occ = w_occ | boards[p*CELLS +: CELLS];
      end
   end

   // Draw is resolved on the last row so it lands together with the final win flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_occ  <= '0;
         r_draw <= 1'b0;
      end else if (w_accept) begin
         r_occ  <= w_occ;
         r_draw <= 1'b0;
      end else if (r_state == S_SCAN && w_last) begin
         r_draw <= (&r_occ) & ~(r_win | w_row_win);
      end
   end

   assign draw = r_draw;
`else
   assign draw = 1'b0;
`endif

   assign busy     = (r_state == S_SCAN);
   assign done     = (r_state == S_DONE);
   assign win      = r_win;
   assign win_mask = r_mask;

endmodule

// File: tb/tb_connect_win_scanner.sv
// Directed bench for connect_win_scanner: default 6x7 instance plus a 4x5 / WIN_LEN=3 / 3-player instance.
module tb_connect_win_scanner;

   logic         clk = 1'b0;
   logic         reset;
   logic [83:0]  boards;
   logic [0:0]   player;
   logic         start;
   logic         busy, done, win, draw;
   logic [41:0]  win_mask;

   logic [59:0]  b_boards;
   logic [1:0]   b_player;
   logic         b_start;
   logic         b_busy, b_done, b_win, b_draw;
   logic [19:0]  b_mask;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   connect_win_scanner u_dut (
      .clk(clk), .reset(reset), .boards(boards), .player(player), .start(start),
      .busy(busy), .done(done), .win(win), .win_mask(win_mask), .draw(draw)
   );

   connect_win_scanner #(.ROWS(4), .COLS(5), .WIN_LEN(3), .PLAYERS(3)) u_small (
      .clk(clk), .reset(reset), .boards(b_boards), .player(b_player), .start(b_start),
      .busy(b_busy), .done(b_done), .win(b_win), .win_mask(b_mask), .draw(b_draw)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: got=%0h", tag, got);
      end
   endtask

   task automatic scan(input logic [83:0] b, input logic p, output int lat, output int nbusy, output logic w1);
      boards = b;
      player = p;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      nbusy = 0;
      w1    = win;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic scan_small(input logic [59:0] b, input logic [1:0] p, output int lat);
      b_boards = b;
      b_player = p;
      b_start  = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      lat     = 1;
      while (!b_done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   localparam logic [41:0] M_T1   = 42'h78000;
   localparam logic [41:0] M_VERT = 42'h1020408;
   localparam logic [41:0] M_T3   = 42'h3E821830101;

   initial begin
      int          lat, nbusy, first, nd;
      logic        w1, cap_win;
      logic [41:0] cap_mask, db;

      reset = 1'b1; start = 1'b0; boards = '0; player = '0;
      b_start = 1'b0; b_boards = '0; b_player = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_win", win, 0);
      chk("rst_mask", win_mask, 0);
      chk("rst_draw", draw, 0);

      // Horizontal run on row 2
      scan({42'h0, M_T1}, 1'b0, lat, nbusy, w1);
      chk("t1_latency", lat, 7);
      chk("t1_busy_cycles", nbusy, 6);
      chk("t1_win", win, 1);
      chk("t1_mask", win_mask, M_T1);
      chk("t1_draw", draw, 0);

      // Vertical run on board 1: wrong player then right player
      scan({M_VERT, 42'h0}, 1'b0, lat, nbusy, w1);
      chk("t2_wrong_win", win, 0);
      chk("t2_wrong_mask", win_mask, 0);
      scan({M_VERT, 42'h0}, 1'b1, lat, nbusy, w1);
      chk("t2_right_win", win, 1);
      chk("t2_right_mask", win_mask, M_VERT);
      scan({42'h0, 42'h1E0}, 1'b0, lat, nbusy, w1);
      chk("t2_wrap_win", win, 0);
      chk("t2_wrap_mask", win_mask, 0);

      // Two diagonals plus a horizontal five
      scan({42'h0, M_T3}, 1'b0, lat, nbusy, w1);
      chk("t3_win", win, 1);
      chk("t3_mask", win_mask, M_T3);

      // Ignored mid-scan start and board change
      boards = {42'h0, M_T1}; player = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; first = 0; nd = 0; cap_win = 1'b0; cap_mask = '0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (done) begin
            nd++;
            if (first == 0) begin
               first    = cyc;
               cap_win  = win;
               cap_mask = win_mask;
            end
         end
         if (cyc == 3) begin
            start  = 1'b1;
            boards = '0;
         end
         if (cyc == 5) start = 1'b0;
         @(posedge clk); #1;
      end
      chk("t4_done_cycle", first, 7);
      chk("t4_done_count", nd, 1);
      chk("t4_win", cap_win, 1);
      chk("t4_mask", cap_mask, M_T1);
      scan({42'h0, M_T3}, 1'b0, lat, nbusy, w1);
      chk("t4_pre_latency", lat, 7);
      scan({42'h0, M_T1}, 1'b0, lat, nbusy, w1);
      chk("t4_done_start_latency", lat, 7);
      chk("t4_done_start_clear", w1, 0);
      chk("t4_done_start_mask", win_mask, M_T1);

      // Reset while scanning row 3
      boards = {42'h0, M_T1}; player = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("t5_pre_reset_win", win, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_done", done, 0);
      chk("t5_rst_win", win, 0);
      chk("t5_rst_mask", win_mask, 0);
      nd = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      chk("t5_no_done", nd, 0);

      // Full board with no 4-run for either player
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++)
            db[r*7+c] = (((c + 2*r) % 4) < 2);
      scan({~db, db}, 1'b0, lat, nbusy, w1);
      chk("t5_full_win", win, 0);
`ifdef CONNECT_DRAW_DETECT_EN
      chk("t5_full_draw", draw, 1);
`else
      chk("t5_full_draw", draw, 0);
`endif

      // Smaller parameter set
      scan_small({20'h82080, 40'h0}, 2'd2, lat);
      chk("t6_latency", lat, 5);
      chk("t6_win", b_win, 1);
      chk("t6_mask", b_mask, 20'h82080);
      scan_small({20'h82080, 40'h0}, 2'd3, lat);
      chk("t6_bad_player_latency", lat, 5);
      chk("t6_bad_player_win", b_win, 0);
      chk("t6_bad_player_mask", b_mask, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/connect_win_scanner.md
# connect_win_scanner

Parametrised, multi-cycle successor to the single-cycle Connect-4 win checker. It snapshots per-player occupancy boards on a start handshake and scans one anchor row per clock in all four line directions. It reports win, the union mask of every winning line, and optionally draw. It sits between the game-control FSM, which issues `start` after each drop, and the display/LED driver, which consumes `win_mask`.

## Interface
Parameters:
- `ROWS`, default 6: board rows; row 0 is the bottom.
- `COLS`, default 7: board columns.
- `WIN_LEN`, default 4: run length that wins. Legal range is 2 ≤ WIN_LEN ≤ max(ROWS,COLS).
- `PLAYERS`, default 2: number of occupancy boards.
- `PW`, default `$clog2(PLAYERS)` (minimum 1): width of `player`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `boards`  in  PLAYERS*ROWS*COLS  occupancy. Bit index is p*ROWS*COLS + r*COLS + c.
- `player`  in  PW  board to test for a win.
- `start`  in  1  request a scan; accepted only when `busy`=0.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse when results are valid.
- `win`  out  1  at least one run of WIN_LEN cells exists on the selected board.
- `win_mask`  out  ROWS*COLS  union of all winning cells; bit index is r*COLS + c.
- `draw`  out  1  board full and no win. Only active when `CONNECT_DRAW_DETECT_EN` is defined.

## Operation
States:
- IDLE
  - `start`=1 snapshots `boards` and `player` into internal registers.
  - Clears `win`, `win_mask` and `draw`, sets row counter to 0, and moves to SCAN.
- SCAN
  - Each cycle processes anchor row `row`, checking every column c of that row.
  - Horizontal: c+WIN_LEN-1 < COLS.
  - Vertical: row+WIN_LEN-1 < ROWS.
  - Diagonal up-right: both bounds above hold.
  - Diagonal down-right: row-(WIN_LEN-1) ≥ 0 and c+WIN_LEN-1 < COLS.
  - Anchors whose run falls outside the board are skipped; no wrap-around.
  - Every matching run ORs all WIN_LEN cells into `win_mask` and sets `win`.
  - After row ROWS-1, moves to DONE.
- DONE
  - Holds for one cycle with `done`=1, then returns to IDLE.
  - `start`=1 in DONE is accepted exactly as in IDLE: the result clears and SCAN begins next cycle. `done` is still seen for that cycle.

Rules:
- `start` while in SCAN is ignored and not queued.
- Changes to `boards` or `player` during SCAN do not affect the result, because the scan works from the snapshot.
- A `player` value ≥ PLAYERS yields `win`=0 and `win_mask`=0 and the scan still completes normally.
- Overlapping and longer runs are supported: five in a row sets 5 mask bits, and crossing lines are unioned.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `win`=0, `win_mask`=0, `draw`=0. The row counter is 0.
- Reset mid-scan aborts immediately to IDLE with all outputs zeroed and no `done`.
- Let edge k be the clock edge that accepts `start`:
  - `busy`=1 for the ROWS cycles following edge k.
  - `done`=1 in the next cycle.
  - Total latency from the accepting edge to `done` is ROWS+1 cycles: 7 at the default size.
- `win`, `win_mask` and `draw` are registered. They are valid while `done`=1 and hold until the next accepted `start`.
- Back-to-back scans, with `start` held high continuously, give one result every ROWS+1 cycles.

## Configuration
- `CONNECT_DRAW_DETECT_EN` defined:
  - The block snapshots the OR of all player boards.
  - In DONE, `draw`=1 if every one of the ROWS*COLS cells is occupied and `win`=0.
- `CONNECT_DRAW_DETECT_EN` undefined: `draw` is tied to 0 and the OR snapshot logic is absent.

## Test plan
1. **Horizontal win, default 6x7, WIN_LEN=4.** Board 0 has cells (2,1)..(2,4) set; `player`=0; pulse `start`.
   - Response: `busy` for 6 cycles, then `done`; `win`=1; `win_mask` bits 15,16,17,18 set and all others 0.
2. **Wrong player / off-board runs.** Board 1 has vertical run (0,3)..(3,3); `player`=0, then `player`=1. Separately, a horizontal run (0,5),(0,6) plus (1,0),(1,1) must not produce a wrap-around win.
   - Response: first scan `win`=0 and mask 0; second scan `win`=1 with mask bits 3,10,17,24; wrap-around case `win`=0.
3. **Diagonals and union.** Board 0 holds up-right run (0,0),(1,1),(2,2),(3,3) and down-right run (5,0),(4,1),(3,2),(2,3), plus a horizontal five (5,2)..(5,6).
   - Response: `win`=1; the mask is exactly the union of all 13 cells, with no extra bits.
4. **Handshake.** Assert `start` again mid-SCAN, and change `boards` mid-SCAN.
   - Response: the second start is ignored; the result reflects the snapshot; `done` occurs exactly once, at cycle 7.
   - Follow-up: `start` in the DONE cycle gives a new `done` 7 cycles later.
5. **Reset mid-scan and draw.**
   - Assert `reset` at SCAN row 3. Response: the next cycle shows `busy`=0 and all outputs 0, with no `done`.
   - With `CONNECT_DRAW_DETECT_EN` defined, load a full 42-cell board with no 4-run. Response: `draw`=1 and `win`=0.
   - Without the macro, the same board gives `draw`=0.
6. **Parameter sweep.** ROWS=4, COLS=5, WIN_LEN=3, PLAYERS=3, `player`=2, board 2 holds (1,2),(2,3),(3,4).
   - Response: `win`=1, mask bits 7,13,19; `done` 5 cycles after start.
